// File: rtl/mtr_ramp.sv
// mtr_ramp: slew-rate limiter feeding the motor driver.
// Moves the registered left/right duties toward latched targets by a bounded
// step once per ramp tick; e_stop ramps both sides to zero at the brake rate.
module mtr_ramp #(
  parameter int RAMP_DIV   = 1024,
  parameter int STEP       = 8,
  parameter int BRAKE_STEP = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_tgt,
  input  logic signed [11:0] right_tgt,
  input  logic               tgt_vld,
  input  logic               e_stop,
  output logic signed [11:0] lft_duty,
  output logic signed [11:0] right_duty,
  output logic               at_tgt,
  output logic               brk_active
);

  localparam int                 DIV_W    = $clog2(RAMP_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic signed [12:0] STEP_N   = 13'(STEP);
  localparam logic signed [12:0] BRAKE_N  = 13'(BRAKE_STEP);

  typedef enum logic [1:0] {IDLE, RAMP, BRAKE} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic signed [11:0] lft_tgt_q, lft_tgt_d, right_tgt_q, right_tgt_d;
  logic signed [11:0] lft_duty_q, lft_duty_d, right_duty_q, right_duty_d;
  logic               at_tgt_q, at_tgt_d, brk_active_q, brk_active_d;
  logic               tick;
  logic signed [11:0] lft_eff, right_eff;
  logic signed [12:0] step_sel;

  // One slew step: jump to the target when within s, otherwise move by s.
  // Working in 13 bits keeps a full 2047 -> -2048 reversal free of wrap.
  function automatic logic signed [11:0] step_toward(
    input logic signed [11:0] cur,
    input logic signed [11:0] tgt,
    input logic signed [12:0] s
  );
    logic signed [12:0] cur_x, tgt_x, diff, mag, nxt;
    cur_x = 13'(cur);
    tgt_x = 13'(tgt);
    diff  = tgt_x - cur_x;
    mag   = diff[12] ? -diff : diff;
    nxt   = diff[12] ? cur_x - s : cur_x + s;
    if (mag <= s) step_toward = tgt;
    else          step_toward = nxt[11:0];
  endfunction

  // Free-running tick divider; tick marks the last count before wrap.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Target latch: e_stop pins both targets to zero and blocks new commands.
  always_comb begin
    lft_tgt_d   = lft_tgt_q;
    right_tgt_d = right_tgt_q;
    if (e_stop) begin
      lft_tgt_d   = '0;
      right_tgt_d = '0;
    end else if (tgt_vld) begin
      lft_tgt_d   = lft_tgt;
      right_tgt_d = right_tgt;
    end
  end

  // Duty stepping on tick, using the target held before this edge (or zero under e_stop).
  always_comb begin
    lft_eff      = e_stop ? 12'sd0 : lft_tgt_q;
    right_eff    = e_stop ? 12'sd0 : right_tgt_q;
    step_sel     = e_stop ? BRAKE_N : STEP_N;
    lft_duty_d   = lft_duty_q;
    right_duty_d = right_duty_q;
    if (tick) begin
      lft_duty_d   = step_toward(lft_duty_q, lft_eff, step_sel);
      right_duty_d = step_toward(right_duty_q, right_eff, step_sel);
    end
  end

  // Mode selection plus the registered status flags derived from the next mode.
  always_comb begin
    state_d = state_q;
    if (e_stop) begin
      state_d = BRAKE;
    end else if (state_q == BRAKE) begin
      state_d = (lft_duty_q == 12'sd0 && right_duty_q == 12'sd0) ? IDLE : RAMP;
    end else if (lft_duty_d == lft_tgt_d && right_duty_d == right_tgt_d) begin
      state_d = IDLE;
    end else begin
      state_d = RAMP;
    end
    at_tgt_d     = (state_d == IDLE);
    brk_active_d = (state_d == BRAKE);
  end

  // All state registers; reset drops the duties to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      lft_tgt_q    <= '0;
      right_tgt_q  <= '0;
      lft_duty_q   <= '0;
      right_duty_q <= '0;
      at_tgt_q     <= 1'b1;
      brk_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      lft_tgt_q    <= lft_tgt_d;
      right_tgt_q  <= right_tgt_d;
      lft_duty_q   <= lft_duty_d;
      right_duty_q <= right_duty_d;
      at_tgt_q     <= at_tgt_d;
      brk_active_q <= brk_active_d;
    end
  end

  assign lft_duty   = lft_duty_q;
  assign right_duty = right_duty_q;
  assign at_tgt     = at_tgt_q;
  assign brk_active = brk_active_q;

endmodule

// File: tb/tb_mtr_ramp.sv
// tb_mtr_ramp: vector table, directed ramp/brake/reset sequences and a
// randomized run, all compared against a cycle-level reference model.
module tb_mtr_ramp;

  localparam int RAMP_DIV   = 4;
  localparam int STEP       = 8;
  localparam int BRAKE_STEP = 64;

  logic               clk = 1'b0;
  logic               rstN;
  logic signed [11:0] lftTgt, rightTgt;
  logic               tgtVld, eStop;
  logic signed [11:0] lftDuty, rightDuty;
  logic               atTgt, brkActive;

  int checks   = 0;
  int failures = 0;

  // Reference model: duties, latched targets, status flags and edges since reset.
  int mLft, mRight, mTgtL, mTgtR, mEdge;
  int mAt, mBrk;

  typedef struct {
    int lt;
    int rt;
    bit vld;
    bit es;
    int expL;
    int expR;
    int expAt;
    int expBrk;
  } vec_t;

  vec_t vecs[12];

  mtr_ramp #(
    .RAMP_DIV  (RAMP_DIV),
    .STEP      (STEP),
    .BRAKE_STEP(BRAKE_STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .lft_tgt   (lftTgt),
    .right_tgt (rightTgt),
    .tgt_vld   (tgtVld),
    .e_stop    (eStop),
    .lft_duty  (lftDuty),
    .right_duty(rightDuty),
    .at_tgt    (atTgt),
    .brk_active(brkActive)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #5ms;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int moveToward(input int cur, input int tgt, input int s);
    if (tgt - cur <= s && cur - tgt <= s) return tgt;
    if (tgt > cur) return cur + s;
    return cur - s;
  endfunction

  function automatic int randTarget();
    case ($urandom_range(0, 3))
      0:       return 2047;
      1:       return -2048;
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, " lft_duty"}, lftDuty, mLft);
    checkOutput({tag, " right_duty"}, rightDuty, mRight);
    checkOutput({tag, " at_tgt"}, atTgt, mAt);
    checkOutput({tag, " brk_active"}, brkActive, mBrk);
  endtask

  task automatic modelReset();
    mLft = 0; mRight = 0; mTgtL = 0; mTgtR = 0;
    mEdge = 0; mAt = 1; mBrk = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit tick;
    int s, effL, effR, oldL, oldR;
    tick = (mEdge % RAMP_DIV) == RAMP_DIV - 1;
    s    = eStop ? BRAKE_STEP : STEP;
    effL = eStop ? 0 : mTgtL;
    effR = eStop ? 0 : mTgtR;
    oldL = mLft;
    oldR = mRight;
    if (tick) begin
      mLft   = moveToward(mLft, effL, s);
      mRight = moveToward(mRight, effR, s);
    end
    if (eStop) begin
      mTgtL = 0; mTgtR = 0;
    end else if (tgtVld) begin
      mTgtL = int'(lftTgt); mTgtR = int'(rightTgt);
    end
    if (eStop)     mAt = 0;
    else if (mBrk) mAt = (oldL == 0 && oldR == 0) ? 1 : 0;
    else           mAt = (mLft == mTgtL && mRight == mTgtR) ? 1 : 0;
    mBrk = eStop ? 1 : 0;
    mEdge++;
  endtask

  task automatic stepCycle(input string tag);
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    compareAll(tag);
  endtask

  // Drive one command for ncyc clocks; tgt_vld is a strobe on the first clock only.
  task automatic applyStimulus(input int lt, input int rt, input bit vld, input bit es, input int ncyc);
    lftTgt   = 12'(lt);
    rightTgt = 12'(rt);
    tgtVld   = vld;
    eStop    = es;
    for (int i = 0; i < ncyc; i++) begin
      stepCycle("cyc");
      tgtVld = 1'b0;
    end
  endtask

  // Called at a falling edge: assert reset between edges, check it bites at once, release.
  task automatic doReset();
    #2;
    rstN = 1'b0; tgtVld = 1'b0; eStop = 1'b0; lftTgt = '0; rightTgt = '0;
    #1;
    checkOutput("rst async lft", lftDuty, 0);
    checkOutput("rst async right", rightDuty, 0);
    checkOutput("rst async at_tgt", atTgt, 1);
    checkOutput("rst async brk", brkActive, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    modelReset();
    compareAll("rst");
  endtask

  initial begin
    int prev, minSeen, expV;
    rstN = 1'b1; tgtVld = 1'b0; eStop = 1'b0; lftTgt = '0; rightTgt = '0;
    modelReset();

    vecs[0]  = '{20, -10, 1, 0, 8, -8, 0, 0};
    vecs[1]  = '{20, -10, 0, 0, 16, -10, 0, 0};
    vecs[2]  = '{20, -10, 0, 0, 20, -10, 1, 0};
    vecs[3]  = '{-100, 30, 1, 0, 12, -2, 0, 0};
    vecs[4]  = '{-100, 30, 0, 1, 0, 0, 0, 1};
    vecs[5]  = '{500, 500, 1, 1, 0, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    vecs[7]  = '{5, -3, 1, 0, 5, -3, 1, 0};
    vecs[8]  = '{5, -3, 1, 0, 5, -3, 1, 0};
    vecs[9]  = '{13, -11, 1, 0, 13, -11, 1, 0};
    vecs[10] = '{22, -20, 1, 0, 21, -19, 0, 0};
    vecs[11] = '{22, -20, 0, 0, 22, -20, 1, 0};

    @(negedge clk);
    doReset();

    // Table: each vector spans exactly one ramp tick.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].lt, vecs[i].rt, vecs[i].vld, vecs[i].es, RAMP_DIV);
      checkOutput($sformatf("vec%0d lft", i), lftDuty, vecs[i].expL);
      checkOutput($sformatf("vec%0d right", i), rightDuty, vecs[i].expR);
      checkOutput($sformatf("vec%0d at_tgt", i), atTgt, vecs[i].expAt);
      checkOutput($sformatf("vec%0d brk", i), brkActive, vecs[i].expBrk);
    end

    // Basic ramp 0 -> 100 in 13 ticks.
    doReset();
    for (int n = 1; n <= 13; n++) begin
      applyStimulus(100, 0, n == 1, 0, RAMP_DIV);
      expV = (8 * n > 100) ? 100 : 8 * n;
      checkOutput($sformatf("ramp100 t%0d lft", n), lftDuty, expV);
      checkOutput("ramp100 right", rightDuty, 0);
      if (n < 13) checkOutput("ramp100 at_tgt low", atTgt, 0);
    end
    applyStimulus(100, 0, 0, 0, 1);
    checkOutput("ramp100 at_tgt high", atTgt, 1);

    // Full reversal 2047 -> -2048 without wrap.
    doReset();
    applyStimulus(2047, 2047, 1, 0, 1024);
    checkOutput("rev start lft", lftDuty, 2047);
    prev = 2047;
    for (int n = 1; n <= 512; n++) begin
      applyStimulus(-2048, -2048, n == 1, 0, RAMP_DIV);
      expV = (2047 - 8 * n < -2048) ? -2048 : 2047 - 8 * n;
      checkOutput("rev lft", lftDuty, expV);
      checkOutput("rev monotonic", (int'(lftDuty) <= prev) ? 1 : 0, 1);
      prev = int'(lftDuty);
    end
    checkOutput("rev end right", rightDuty, -2048);

    // Emergency brake from the extremes; commands during e_stop are ignored.
    doReset();
    applyStimulus(2047, -2048, 1, 0, 1024);
    for (int n = 1; n <= 34; n++) begin
      applyStimulus((n == 10) ? 500 : 0, (n == 10) ? 500 : 0, n == 10, 1, RAMP_DIV);
      checkOutput("brake brk_active", brkActive, 1);
      if (n == 31) begin
        checkOutput("brake t31 lft", lftDuty, 63);
        checkOutput("brake t31 right", rightDuty, -64);
      end
      if (n >= 32) begin
        checkOutput("brake zero lft", lftDuty, 0);
        checkOutput("brake zero right", rightDuty, 0);
        checkOutput("brake at_tgt", atTgt, 0);
      end
    end

    // Partial brake to 320 then release: normal-rate ramp to zero, then a fresh command.
    doReset();
    applyStimulus(1600, 1600, 1, 0, 800);
    applyStimulus(0, 0, 0, 1, 80);
    checkOutput("partial lft", lftDuty, 320);
    applyStimulus(0, 0, 0, 0, 39 * RAMP_DIV);
    checkOutput("release t39 lft", lftDuty, 8);
    checkOutput("release t39 at_tgt", atTgt, 0);
    checkOutput("release brk", brkActive, 0);
    applyStimulus(0, 0, 0, 0, RAMP_DIV);
    checkOutput("release t40 right", rightDuty, 0);
    checkOutput("release t40 at_tgt", atTgt, 1);
    applyStimulus(50, 50, 1, 0, 7 * RAMP_DIV);
    checkOutput("post lft", lftDuty, 50);
    checkOutput("post at_tgt", atTgt, 1);

    // Retarget mid-ramp at 200 toward -40: no overshoot.
    doReset();
    applyStimulus(400, 0, 1, 0, 25 * RAMP_DIV);
    checkOutput("retgt mid lft", lftDuty, 200);
    applyStimulus(-40, 0, 1, 0, RAMP_DIV);
    checkOutput("retgt first lft", lftDuty, 192);
    minSeen = 192;
    for (int n = 0; n < 31; n++) begin
      applyStimulus(-40, 0, 0, 0, RAMP_DIV);
      if (int'(lftDuty) < minSeen) minSeen = int'(lftDuty);
    end
    checkOutput("retgt end lft", lftDuty, -40);
    checkOutput("retgt overshoot", minSeen, -40);

    // Reset mid-ramp between ticks, then confirm the divider restarts from zero.
    doReset();
    applyStimulus(400, -400, 1, 0, 42);
    checkOutput("midrst pre lft", lftDuty, 80);
    doReset();
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("midrst hold lft", lftDuty, 0);
    checkOutput("midrst hold right", rightDuty, 0);
    applyStimulus(16, 16, 1, 0, RAMP_DIV - 1);
    checkOutput("midrst pretick lft", lftDuty, 0);
    applyStimulus(16, 16, 0, 0, 1);
    checkOutput("midrst tick lft", lftDuty, 8);

    // Randomized run against the model.
    doReset();
    begin
      bit es = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 99) < 2) es = ~es;
        applyStimulus(randTarget(), randTarget(), $urandom_range(0, 7) == 0, es, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
